// File: rtl/mips_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: op codes, FSM states
// and the iteration counter width helper.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } md_state_t;

  function automatic int md_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring shift-subtract for divide, chosen by is_div.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Multiply: rem holds the upper product half, quo the multiplier shifting out LSB first.
  // Divide: rem is the partial remainder, quo the dividend shifting out MSB first.
  always_comb begin
    sum     = rem_in + (quo_in[0] ? {1'b0, opnd} : '0);
    shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    rem_out = shifted;
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!is_div) begin
      rem_out = {1'b0, sum[WIDTH:1]};
      quo_out = {sum[0], quo_in[WIDTH-1:1]};
    end else if (!diff[WIDTH+1]) begin
      rem_out = diff[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair, one bit per cycle.
// Optional MTHI/MTLO write ports are enabled by defining MULDIV_MTHI_MTLO_EN.
//
// state  | meaning
// S_IDLE | waiting for start; busy=0
// S_CALC | WIDTH shift-add / shift-subtract steps on magnitudes
// S_SIGN | sign fix-up, hi/lo written, done pulsed
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MTHI_MTLO_EN
  input  logic [WIDTH-1:0] wd,
  input  logic             hi_we,
  input  logic             lo_we,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = md_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  md_state_t state, state_nx;
  logic accept, calc_en, sign_en;

  logic [CW-1:0]    cnt;
  logic             is_div_q, neg_q, neg_rem_q, bzero_q;
  logic [WIDTH:0]   rem, rem_nx;
  logic [WIDTH-1:0] quo, quo_nx, opnd;

  logic             div_op, sgn_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign sgn_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    calc_en  = 1'b0;
    sign_en  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = S_CALC;
      end
      S_CALC: begin
        calc_en = 1'b1;
        if (cnt == CW'(1)) state_nx = S_SIGN;
      end
      S_SIGN: begin
        sign_en  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .rem_in  (rem),
    .quo_in  (quo),
    .opnd    (opnd),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // A zero divisor leaves the dividend in rem, so only the quotient needs forcing.
  assign prod     = {rem[WIDTH-1:0], quo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = bzero_q ? '1 : (neg_q ? -quo : quo);
  assign rem_fix  = neg_rem_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      opnd      <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= sign_en;
      if (accept) begin
        cnt       <= CNT_LOAD;
        is_div_q  <= div_op;
        neg_q     <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q <= sgn_op && a[WIDTH-1];
        bzero_q   <= div_op && (b == '0);
        rem       <= '0;
        quo       <= a_mag;
        opnd      <= b_mag;
        div_zero  <= 1'b0;
      end else if (calc_en) begin
        cnt <= cnt - CW'(1);
        rem <= rem_nx;
        quo <= quo_nx;
      end
      if (sign_en) begin
        div_zero <= bzero_q;
        if (is_div_q) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
`ifdef MULDIV_MTHI_MTLO_EN
      else if (!busy) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops checked
// against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_MTHI_MTLO_EN
  logic [W-1:0] wd;
  logic         hi_we, lo_we;
`endif

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    longint       due;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic [W-1:0] hold_hi = '0, hold_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
`ifdef MULDIV_MTHI_MTLO_EN
    .wd       (wd),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
`endif
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    longint sx, sy;
    logic [63:0] p, q, m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0; q = '0; m = '0;
    r.op = o; r.dz = 1'b0; r.due = 0;
    case (o)
      2'b00: p = sx * sy;
      2'b01: p = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == '0) begin
          q = '1; m = {32'b0, x}; r.dz = 1'b1;
        end else if (o == 2'b10) begin
          q = sx / sy; m = sx % sy;
        end else begin
          q = {32'b0, x} / {32'b0, y}; m = {32'b0, x} % {32'b0, y};
        end
      end
    endcase
    if (o[1]) begin r.hi = m[31:0]; r.lo = q[31:0]; end
    else      begin r.hi = p[63:32]; r.lo = p[31:0]; end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: pops an expectation on every done and also polices hold/timeout.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_done hi=%h lo=%h at cycle %0d", hi, lo, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (hi !== mon_e.hi || lo !== mon_e.lo || div_zero !== mon_e.dz || cyc != mon_e.due) begin
            errors++;
            $display("FAIL result op=%0d got hi=%h lo=%h dz=%b cyc=%0d exp hi=%h lo=%h dz=%b cyc=%0d",
                     mon_e.op, hi, lo, div_zero, cyc, mon_e.hi, mon_e.lo, mon_e.dz, mon_e.due);
          end
          hold_hi = mon_e.hi;
          hold_lo = mon_e.lo;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL done_timeout op=%0d expected at cycle %0d, now %0d", sb[0].op, sb[0].due, cyc);
        mon_e = sb.pop_front();
      end
      if (busy) begin
        checks++;
        if (hi !== hold_hi || lo !== hold_lo) begin
          errors++;
          $display("FAIL hold got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, hold_hi, hold_lo);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_wait busy=%b after %0d cycles, required 0", busy, n);
      return;
    end
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    e.due = cyc + W + 2;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_dz_clear", 64'(div_zero), 64'(0));
  endtask

  task automatic spur(input int n);
    repeat (n) @(negedge clock);
    start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef MULDIV_MTHI_MTLO_EN
    wd = '0; hi_we = 1'b0; lo_we = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset_n = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFF9, 32'd3);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd7, 32'd2);
    issue(2'b11, 32'h0000_1234, 32'd0);
    issue(2'b01, 32'd5, 32'd6);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'd0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);

    // Starts while busy must be ignored; the next issue lands in the done cycle.
    issue(2'b00, 32'd123456, 32'hFFFF_0001);
    spur(0);
    spur(3);
    spur(14);
    issue(2'b11, 32'hDEAD_BEEF, 32'd17);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (r == 0) rb = '0;
      else if (r == 1) rb = W'($urandom_range(1, 15));
      else if (r == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      issue(ro, ra, rb);
    end

    // Reset in the middle of CALC aborts with no done.
    issue(2'b01, $urandom, $urandom);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    hold_hi = '0;
    hold_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (45) @(negedge clock);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);

`ifdef MULDIV_MTHI_MTLO_EN
    n = 0;
    while ((busy || sb.size() > 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    hi_we = 1'b1; wd = 32'hA5A5_A5A5;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi_idle", 64'(hi), 64'(32'hA5A5_A5A5));
    hold_hi = 32'hA5A5_A5A5;
    lo_we = 1'b1; wd = 32'h0F0F_0F0F;
    @(negedge clock);
    lo_we = 1'b0;
    check("mtlo_idle", 64'(lo), 64'(32'h0F0F_0F0F));
    hold_lo = 32'h0F0F_0F0F;
    issue(2'b01, 32'd3, 32'd5);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234_5678;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_busy", 64'(hi), 64'(32'hA5A5_A5A5));
`endif

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d results outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
